// File: rtl/uart_pkg.sv
// Shared definitions for the file-transfer UART status path.
// - arb_state_e : transmitter arbiter states
// - BYTE_W      : width of one UART byte lane
// - CMD_START   : loader protocol start-command byte, shared by the status producers
package uart_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CMD_START = 8'h84;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_SEND      = 2'd1,
    ARB_WAIT_BUSY = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte-stream requesters, the arbiter and the async transmitter.
// - req_valid/req_data/req_last : per-lane byte offer (lane i = req_data[8i+7:8i])
// - req_ready                   : one-cycle accept strobe, owner lane only
// - grant                       : one-hot current owner, 0 when idle
// - tx_start/tx_data/tx_busy    : transmitter pins
// - abort                       : message dropped by the stall watchdog
// Modport master is the arbiter side, slave is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  import uart_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*BYTE_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        grant;
  logic                   tx_start;
  logic [BYTE_W-1:0]      tx_data;
  logic                   tx_busy;
  logic                   abort;

  modport master (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, grant, tx_start, tx_data, abort
  );

  modport slave (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, grant, tx_start, tx_data, abort
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
// - req : request vector
// - ptr : index of the previous winner; the search starts at ptr+1 and wraps modulo NREQ
// - gnt : one-hot winner (0 when no request)
// - any : at least one request is set
module rr_picker #(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic                    any
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] idx;
  logic             found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one async transmitter between NREQ byte-stream requesters. A requester owns the
// transmitter for a whole message (until its byte flagged req_last is handed over); owners
// rotate round-robin. A stall watchdog drops a message whose owner goes quiet.
// Ports:
// - clk, reset_n : clock and asynchronous active-low reset
// - bus          : uart_tx_arbiter_if master modport (requester lanes + transmitter pins)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned STALL_MAX = 255,
  parameter int unsigned BUSY_WAIT = 3
) (
  input logic               clk,
  input logic               reset_n,
  uart_tx_arbiter_if.master bus
);

  localparam int unsigned PTR_W   = $clog2(NREQ);
  localparam int unsigned STALL_W = $clog2(STALL_MAX + 1);
  localparam int unsigned BUSY_W  = $clog2(BUSY_WAIT + 1);

  localparam logic [1:0] ST_IDLE      = ARB_IDLE;
  localparam logic [1:0] ST_SEND      = ARB_SEND;
  localparam logic [1:0] ST_WAIT_BUSY = ARB_WAIT_BUSY;

  // Decision happens on the cycle whose increment would reach the limit.
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_MAX - 1);
  localparam logic [BUSY_W-1:0]  BUSY_LAST  = BUSY_W'(BUSY_WAIT - 1);

  logic [1:0]         state_q, state_d;
  logic [NREQ-1:0]    grant_q, grant_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [BUSY_W-1:0]  bwait_q, bwait_d;
  logic               last_q, last_d;
  logic               tx_start_q, tx_start_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic               abort_q, abort_d;

  logic [NREQ-1:0]    pick_gnt;
  logic               pick_any;
  logic [PTR_W-1:0]   owner;
  logic [BYTE_W-1:0]  owner_data;
  logic               owner_valid;
  logic               owner_last;
  logic               accept;

  rr_picker #(
    .NREQ(NREQ)
  ) u_rr_picker (
    .req(bus.req_valid),
    .ptr(ptr_q),
    .gnt(pick_gnt),
    .any(pick_any)
  );

  // Owner index and its lane, decoded from the one-hot grant.
  always_comb begin
    owner      = '0;
    owner_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_q[i]) begin
        owner      = PTR_W'(i);
        owner_data = bus.req_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  assign owner_valid = bus.req_valid[owner];
  assign owner_last  = bus.req_last[owner];

  // Never start while the transmitter is still serialising the previous byte.
  assign accept = (state_q == ST_SEND) && owner_valid && !bus.tx_busy;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    stall_d    = stall_q;
    bwait_d    = bwait_q;
    last_d     = last_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    abort_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_gnt;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept) begin
          tx_data_d  = owner_data;
          tx_start_d = 1'b1;
          last_d     = owner_last;
          stall_d    = '0;
          bwait_d    = '0;
          state_d    = ST_WAIT_BUSY;
        end else if (!owner_valid) begin
          if (stall_q >= STALL_LAST) begin
            abort_d = 1'b1;
            grant_d = '0;
            ptr_d   = owner;
            stall_d = '0;
            state_d = ST_IDLE;
          end else begin
            stall_d = stall_q + 1'b1;
          end
        end
      end
      ST_WAIT_BUSY: begin
        // Busy-wait timeout guards against a transmitter that never raised busy.
        if (bus.tx_busy || bwait_q >= BUSY_LAST) begin
          bwait_d = '0;
          if (last_q) begin
            ptr_d   = owner;
            grant_d = '0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_SEND;
          end
        end else begin
          bwait_d = bwait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      ptr_q      <= PTR_W'(NREQ - 1);
      stall_q    <= '0;
      bwait_q    <= '0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ptr_q      <= ptr_d;
      stall_q    <= stall_d;
      bwait_q    <= bwait_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      abort_q    <= abort_d;
    end
  end

  assign bus.req_ready = accept ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.abort     = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: lane drivers fed from per-lane byte queues, a transmitter model
// that raises busy the cycle after a start, a monitor logging starts/readies/grants/aborts,
// and a round-robin message-order reference model.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int unsigned NREQ      = 4;
  localparam int unsigned STALL_MAX = 255;
  localparam int unsigned BUSY_WAIT = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ(NREQ),
    .STALL_MAX(STALL_MAX),
    .BUSY_WAIT(BUSY_WAIT)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  bit [8:0] lane_q [NREQ][$];  // {last, data}

  bit busy_tied = 1'b0;
  int busy_len = 10;
  int busy_left = 0;
  int busy_fall_cyc = -1;

  int start_lane_q[$];
  logic [7:0] start_data_q[$];
  int start_cyc_q[$];
  int ready_cyc_q[$];
  int ready_lane_q[$];
  int abort_cyc_q[$];
  int grant_log_q[$];
  int start_busy_viol = 0;
  int ready_viol = 0;
  logic [NREQ-1:0] prev_grant = '0;

  int exp_lane_q[$];
  logic [7:0] exp_data_q[$];
  int exp_grant_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int onehot_idx(input logic [NREQ-1:0] v);
    int r = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < NREQ; i++) begin
      if (lane_q[i].size() > 0) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[i*8 +: 8] = lane_q[i][0][7:0];
        bus.req_last[i]        = lane_q[i][0][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[i*8 +: 8] = 8'h00;
        bus.req_last[i]        = 1'b0;
      end
    end
  endtask

  // Lane drivers: a byte leaves its queue on the edge where its lane saw req_ready.
  initial begin
    logic [NREQ-1:0] rdy;
    drive_lanes();
    forever begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++)
        if (rdy[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
      drive_lanes();
    end
  end

  // Transmitter model; not affected by the arbiter reset.
  initial begin
    logic st;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      st = bus.tx_start;
      @(posedge clk);
      #1;
      if (busy_tied) begin
        bus.tx_busy = 1'b0;
        busy_left   = 0;
      end else if (bus.tx_busy) begin
        busy_left--;
        if (busy_left <= 0) begin
          bus.tx_busy   = 1'b0;
          busy_fall_cyc = cyc;
        end
      end else if (st === 1'b1) begin
        bus.tx_busy = 1'b1;
        busy_left   = busy_len;
      end
    end
  end

  // Monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tx_start === 1'b1) begin
        start_lane_q.push_back(onehot_idx(bus.grant));
        start_data_q.push_back(bus.tx_data);
        start_cyc_q.push_back(cyc);
        if (bus.tx_busy) start_busy_viol++;
      end
      if (bus.req_ready !== '0) begin
        ready_cyc_q.push_back(cyc);
        ready_lane_q.push_back(onehot_idx(bus.req_ready));
        if ((bus.req_ready & ~bus.grant) != '0 || $countones(bus.req_ready) != 1) ready_viol++;
      end
      if (bus.abort === 1'b1) abort_cyc_q.push_back(cyc);
      if (bus.grant !== prev_grant && bus.grant !== '0) grant_log_q.push_back(onehot_idx(bus.grant));
      prev_grant = bus.grant;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    start_lane_q.delete(); start_data_q.delete(); start_cyc_q.delete();
    ready_cyc_q.delete(); ready_lane_q.delete(); abort_cyc_q.delete(); grant_log_q.delete();
    start_busy_viol = 0;
    ready_viol = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NREQ; i++) lane_q[i].delete();
    repeat (2) @(posedge clk);
    for (int i = 0; i < 400; i++) begin
      if (!bus.tx_busy) break;
      @(posedge clk);
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    clear_logs();
  endtask

  // Reference: messages leave in round-robin order over lanes with pending messages,
  // starting after the previous owner (lane NREQ-1 before the first message).
  task automatic build_expected();
    bit [8:0] mq [NREQ][$];
    bit [8:0] e;
    int ptr;
    int idx;
    exp_lane_q.delete(); exp_data_q.delete(); exp_grant_q.delete();
    for (int i = 0; i < NREQ; i++) mq[i] = lane_q[i];
    ptr = NREQ - 1;
    for (int m = 0; m < 1000; m++) begin
      idx = -1;
      for (int k = 1; k <= NREQ; k++) begin
        int j = (ptr + k) % NREQ;
        if (idx < 0 && mq[j].size() > 0) idx = j;
      end
      if (idx < 0) break;
      exp_grant_q.push_back(idx);
      do begin
        e = mq[idx].pop_front();
        exp_lane_q.push_back(idx);
        exp_data_q.push_back(e[7:0]);
      end while (!e[8] && mq[idx].size() > 0);
      ptr = idx;
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    tests_run++;
    if (bus.grant !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_grant: got %b, expected 0000", bus.grant);
    end
    tests_run++;
    if (bus.req_ready !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_req_ready: got %b, expected 0000", bus.req_ready);
    end
    tests_run++;
    if (bus.tx_start !== 1'b0) begin
      tests_failed++; $display("FAIL reset_tx_start: got %b, expected 0", bus.tx_start);
    end
    tests_run++;
    if (bus.tx_data !== 8'h00) begin
      tests_failed++; $display("FAIL reset_tx_data: got %h, expected 00", bus.tx_data);
    end
    tests_run++;
    if (bus.abort !== 1'b0) begin
      tests_failed++; $display("FAIL reset_abort: got %b, expected 0", bus.abort);
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    clear_logs();
  endtask

  task automatic test_single_byte();
    bit ok = 0;
    busy_len = 20;
    do_reset();
    lane_q[0].push_back({1'b1, 8'h55});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_busy === 1'b1) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL single_busy_rise: busy never rose, expected rise within 50");
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.grant !== 4'b0000 || bus.tx_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_grant_release: got grant %b busy %b, expected 0000 busy 1",
               bus.grant, bus.tx_busy);
    end
    repeat (30) @(negedge clk);
    tests_run++;
    if (start_lane_q.size() != 1) begin
      tests_failed++; $display("FAIL single_start_count: got %0d, expected 1", start_lane_q.size());
    end else begin
      tests_run++;
      if (start_data_q[0] !== 8'h55 || start_lane_q[0] != 0) begin
        tests_failed++;
        $display("FAIL single_data: got lane %0d data %h, expected lane 0 data 55",
                 start_lane_q[0], start_data_q[0]);
      end
    end
  endtask

  task automatic test_contention();
    bit ok = 0;
    busy_len = 10;
    do_reset();
    for (int l = 0; l < NREQ; l++) begin
      lane_q[l].push_back({1'b0, 8'($urandom)});
      lane_q[l].push_back({1'b1, 8'($urandom)});
    end
    build_expected();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (start_lane_q.size() >= exp_lane_q.size()) begin ok = 1; break; end
    end
    repeat (30) @(negedge clk);
    tests_run++;
    if (!ok || start_lane_q.size() != 8) begin
      tests_failed++; $display("FAIL contention_count: got %0d starts, expected 8", start_lane_q.size());
    end
    for (int i = 0; i < exp_lane_q.size() && i < start_lane_q.size(); i++) begin
      tests_run++;
      if (start_lane_q[i] != exp_lane_q[i] || start_data_q[i] !== exp_data_q[i]) begin
        tests_failed++;
        $display("FAIL contention_byte%0d: got lane %0d data %h, expected lane %0d data %h",
                 i, start_lane_q[i], start_data_q[i], exp_lane_q[i], exp_data_q[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (grant_log_q.size() <= i || grant_log_q[i] != i) begin
        tests_failed++;
        $display("FAIL contention_grant%0d: got %0d, expected %0d", i,
                 (grant_log_q.size() > i) ? grant_log_q[i] : -1, i);
      end
    end
    tests_run++;
    if (start_busy_viol != 0 || ready_viol != 0) begin
      tests_failed++;
      $display("FAIL contention_gating: got %0d busy starts %0d stray readies, expected 0 0",
               start_busy_viol, ready_viol);
    end
  endtask

  task automatic test_rotation();
    bit ok = 0;
    busy_len = 6;
    do_reset();
    for (int m = 0; m < 3; m++) begin
      lane_q[1].push_back({1'b1, 8'($urandom)});
      lane_q[2].push_back({1'b1, 8'($urandom)});
    end
    build_expected();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (start_lane_q.size() >= exp_lane_q.size()) begin ok = 1; break; end
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (!ok || grant_log_q.size() != 6) begin
      tests_failed++; $display("FAIL rotation_count: got %0d grants, expected 6", grant_log_q.size());
    end
    for (int i = 0; i < 6 && i < grant_log_q.size(); i++) begin
      tests_run++;
      if (grant_log_q[i] != exp_grant_q[i] || grant_log_q[i] != ((i % 2) + 1)) begin
        tests_failed++;
        $display("FAIL rotation_grant%0d: got %0d, expected %0d", i, grant_log_q[i], (i % 2) + 1);
      end
    end
    for (int i = 0; i < exp_lane_q.size() && i < start_lane_q.size(); i++) begin
      tests_run++;
      if (start_data_q[i] !== exp_data_q[i]) begin
        tests_failed++;
        $display("FAIL rotation_byte%0d: got %h, expected %h", i, start_data_q[i], exp_data_q[i]);
      end
    end
  endtask

  // Accept cycle, two WAIT_BUSY cycles (start, busy seen), STALL_MAX idle SEND cycles,
  // then the abort cycle: STALL_MAX+3 cycles from the accept strobe.
  task automatic test_stall();
    bit ok = 0;
    logic [7:0] d3;
    busy_len = 20;
    do_reset();
    d3 = 8'($urandom);
    lane_q[2].push_back({1'b0, 8'($urandom)});
    lane_q[3].push_back({1'b1, d3});
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (bus.abort === 1'b1) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++; $display("FAIL stall_abort: no abort seen, expected one within 600 cycles");
    end else begin
      tests_run++;
      if (bus.grant !== 4'b0000) begin
        tests_failed++; $display("FAIL stall_grant_clear: got %b, expected 0000", bus.grant);
      end
      tests_run++;
      if (ready_cyc_q.size() != 1 || ready_lane_q[0] != 2 ||
          abort_cyc_q[0] - ready_cyc_q[0] != STALL_MAX + 3) begin
        tests_failed++;
        $display("FAIL stall_timing: got %0d readies, delay %0d, expected 1 ready, delay %0d",
                 ready_cyc_q.size(), (ready_cyc_q.size() > 0) ? abort_cyc_q[0] - ready_cyc_q[0] : -1,
                 STALL_MAX + 3);
      end
      @(negedge clk);
      tests_run++;
      if (bus.grant !== 4'b1000 || bus.abort !== 1'b0) begin
        tests_failed++;
        $display("FAIL stall_next_grant: got grant %b abort %b, expected 1000 0", bus.grant, bus.abort);
      end
    end
    repeat (40) @(negedge clk);
    tests_run++;
    if (start_lane_q.size() != 2 || start_data_q[1] !== d3 || start_lane_q[1] != 3) begin
      tests_failed++;
      $display("FAIL stall_lane3_byte: got %0d starts, expected 2 with lane 3 data %h",
               start_lane_q.size(), d3);
    end
    tests_run++;
    if (ready_viol != 0 || abort_cyc_q.size() != 1) begin
      tests_failed++;
      $display("FAIL stall_atomic: got %0d stray readies %0d aborts, expected 0 1",
               ready_viol, abort_cyc_q.size());
    end
  endtask

  task automatic test_missing_busy();
    int zero_cyc = -1;
    logic [7:0] d [3];
    busy_tied = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      d[i] = 8'($urandom);
      lane_q[1].push_back({(i == 2), d[i]});
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ready_cyc_q.size() == 3 && bus.grant === 4'b0000) begin zero_cyc = cyc; break; end
    end
    tests_run++;
    if (zero_cyc < 0) begin
      tests_failed++;
      $display("FAIL missing_busy_done: got %0d bytes, expected 3 within 200 cycles", ready_cyc_q.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        tests_run++;
        if (ready_cyc_q[i] - ready_cyc_q[i-1] != BUSY_WAIT + 1) begin
          tests_failed++;
          $display("FAIL missing_busy_gap%0d: got %0d, expected %0d", i,
                   ready_cyc_q[i] - ready_cyc_q[i-1], BUSY_WAIT + 1);
        end
      end
      tests_run++;
      if (zero_cyc - ready_cyc_q[2] != BUSY_WAIT + 1) begin
        tests_failed++;
        $display("FAIL missing_busy_release: got %0d, expected %0d", zero_cyc - ready_cyc_q[2],
                 BUSY_WAIT + 1);
      end
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if (start_data_q.size() <= i || start_data_q[i] !== d[i]) begin
          tests_failed++;
          $display("FAIL missing_busy_byte%0d: got %h, expected %h", i,
                   (start_data_q.size() > i) ? start_data_q[i] : 8'hxx, d[i]);
        end
      end
    end
    busy_tied = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit ok = 0;
    int n0;
    busy_len = 30;
    do_reset();
    lane_q[0].push_back({1'b0, 8'($urandom)});
    lane_q[0].push_back({1'b0, 8'($urandom)});
    lane_q[0].push_back({1'b1, 8'($urandom)});
    lane_q[1].push_back({1'b1, 8'($urandom)});
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.tx_busy === 1'b1) begin ok = 1; break; end
    end
    @(posedge clk);
    #2 reset_n = 1'b0;
    busy_fall_cyc = -1;
    #1;
    tests_run++;
    if (!ok || bus.grant !== '0 || bus.req_ready !== '0 || bus.tx_start !== 1'b0 ||
        bus.tx_data !== 8'h00 || bus.abort !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got grant %b ready %b start %b data %h abort %b, expected 0s",
               bus.grant, bus.req_ready, bus.tx_start, bus.tx_data, bus.abort);
    end
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    n0 = start_cyc_q.size();
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (start_cyc_q.size() > n0) begin ok = 1; break; end
    end
    tests_run++;
    if (!ok || busy_fall_cyc < 0 || start_cyc_q[n0] <= busy_fall_cyc) begin
      tests_failed++;
      $display("FAIL reset_mid_restart: got start seen %0d busy fall cycle %0d, expected start after fall",
               ok, busy_fall_cyc);
    end
    tests_run++;
    if (start_busy_viol != 0) begin
      tests_failed++; $display("FAIL reset_mid_busy_start: got %0d, expected 0", start_busy_viol);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 3; it++) begin
      bit ok = 0;
      int total = 0;
      busy_len = int'($urandom_range(12, 2));
      do_reset();
      for (int l = 0; l < NREQ; l++) begin
        int nmsg = int'($urandom_range(3, 0));
        if (l == it) nmsg = nmsg + 1;
        for (int m = 0; m < nmsg; m++) begin
          int len = int'($urandom_range(3, 1));
          for (int b = 0; b < len; b++) lane_q[l].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      build_expected();
      total = exp_lane_q.size();
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (start_lane_q.size() >= total) begin ok = 1; break; end
      end
      repeat (busy_len + 20) @(negedge clk);
      tests_run++;
      if (!ok || start_lane_q.size() != total) begin
        tests_failed++;
        $display("FAIL random%0d_count: got %0d bytes, expected %0d", it, start_lane_q.size(), total);
      end
      for (int i = 0; i < total && i < start_lane_q.size(); i++) begin
        tests_run++;
        if (start_lane_q[i] != exp_lane_q[i] || start_data_q[i] !== exp_data_q[i]) begin
          tests_failed++;
          $display("FAIL random%0d_byte%0d: got lane %0d data %h, expected lane %0d data %h",
                   it, i, start_lane_q[i], start_data_q[i], exp_lane_q[i], exp_data_q[i]);
        end
      end
      tests_run++;
      if (grant_log_q != exp_grant_q) begin
        tests_failed++;
        $display("FAIL random%0d_grants: got %0d grants, expected %0d in rotation order",
                 it, grant_log_q.size(), exp_grant_q.size());
      end
      tests_run++;
      if (start_busy_viol != 0 || ready_viol != 0) begin
        tests_failed++;
        $display("FAIL random%0d_gating: got %0d busy starts %0d stray readies, expected 0 0",
                 it, start_busy_viol, ready_viol);
      end
    end
  endtask

  initial begin
    #3;
    test_reset();
    test_single_byte();
    test_contention();
    test_rotation();
    test_stall();
    test_missing_busy();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
